// File: rtl/ray_dispatcher.sv
// ray_dispatcher: walks the frame in raster order, issues one ray at a time and writes each result to the framebuffer
module ray_dispatcher #(
   parameter int WIDTH = 1280,
   parameter int HEIGHT = 720,
   parameter int CAM_LATENCY = 4,
   parameter int COLOR_W = 72,
   parameter int TIMEOUT = 65535,
   parameter logic [COLOR_W-1:0] ERR_COLOR = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             continuous,
   output logic [10:0]                      pixel_h,
   output logic [9:0]                       pixel_v,
   output logic                             ray_valid,
   input  logic                             ray_done,
   input  logic [COLOR_W-1:0]               pixel_color,
   output logic                             fb_wr_valid,
   input  logic                             fb_wr_ready,
   output logic [$clog2(WIDTH*HEIGHT)-1:0]  fb_wr_addr,
   output logic [COLOR_W-1:0]               fb_wr_data,
   output logic                             busy,
   output logic                             frame_done,
   output logic [15:0]                      frame_count,
   output logic                             timeout_err
);
   localparam int AW = $clog2(WIDTH * HEIGHT);
   localparam int LW = $clog2(CAM_LATENCY + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, WRITE, ADVANCE} state_t;
   state_t state;
   logic [LW-1:0] lat;
   logic [TW-1:0] wcnt;
   logic last;
   always_comb begin
      busy = state != IDLE;
      last = pixel_h == 11'(WIDTH - 1) && pixel_v == 10'(HEIGHT - 1);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pixel_h <= '0;
         pixel_v <= '0;
         ray_valid <= 1'b0;
         fb_wr_valid <= 1'b0;
         fb_wr_addr <= '0;
         fb_wr_data <= '0;
         frame_done <= 1'b0;
         frame_count <= '0;
         timeout_err <= 1'b0;
         lat <= '0;
         wcnt <= '0;
      end else begin
         ray_valid <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               pixel_h <= '0;
               pixel_v <= '0;
               lat <= '0;
               state <= SETUP;
            end
            SETUP: begin
               lat <= lat + 1'b1;
               if (lat == LW'(CAM_LATENCY - 1)) state <= ISSUE;
            end
            ISSUE: begin
               ray_valid <= 1'b1;
               wcnt <= '0;
               fb_wr_addr <= AW'(32'(pixel_v) * 32'(WIDTH) + 32'(pixel_h));
               state <= WAIT;
            end
            WAIT: if (ray_done) begin
               fb_wr_data <= pixel_color;
               fb_wr_valid <= 1'b1;
               state <= WRITE;
            end else if (wcnt == TW'(TIMEOUT)) begin
               fb_wr_data <= ERR_COLOR;
               timeout_err <= 1'b1;
               fb_wr_valid <= 1'b1;
               state <= WRITE;
            end else wcnt <= wcnt + 1'b1;
            WRITE: if (fb_wr_ready) begin
               fb_wr_valid <= 1'b0;
               state <= ADVANCE;
            end
            ADVANCE: begin
               lat <= '0;
               if (last) begin
                  pixel_h <= '0;
                  pixel_v <= '0;
                  frame_done <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  state <= continuous ? SETUP : IDLE;
               end else begin
                  pixel_h <= pixel_h == 11'(WIDTH - 1) ? '0 : pixel_h + 11'd1;
                  pixel_v <= pixel_h == 11'(WIDTH - 1) ? pixel_v + 10'd1 : pixel_v;
                  state <= SETUP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: directed checks of a 4x2 frame with a tracer model, backpressure, timeout, continuous mode and reset
module tb_ray_dispatcher;
   localparam logic [71:0] ERR = 72'hDEAD_BEEF;
   logic clk = 1'b0;
   logic rst_n, start, continuous, ray_valid, ray_done, fb_wr_valid, fb_wr_ready;
   logic busy, frame_done, timeout_err;
   logic [10:0] pixel_h;
   logic [9:0] pixel_v;
   logic [71:0] pixel_color, fb_wr_data;
   logic [2:0] fb_wr_addr;
   logic [15:0] frame_count;
   int n_chk = 0, n_pass = 0;
   int mute_a = -1, sim_a = -1, long_a = -1, stall_a = -1, stall_left = 0;
   int cyc = 0, age = 0, rv_idx = 0, rv_last = -1, rv_cyc = 0, wr_idx = 0, n_wr = 0, n_fd = 0, fc_exp = 0;
   logic late_fired = 1'b0;

   ray_dispatcher #(.WIDTH(4), .HEIGHT(2), .CAM_LATENCY(2), .COLOR_W(72), .TIMEOUT(20), .ERR_COLOR(ERR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
      .pixel_h(pixel_h), .pixel_v(pixel_v), .ray_valid(ray_valid), .ray_done(ray_done),
      .pixel_color(pixel_color), .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
      .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .busy(busy), .frame_done(frame_done),
      .frame_count(frame_count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int exp_lat(input int a);
      return (a == mute_a || a == sim_a) ? 21 : 6;
   endfunction

   // tracer model: colour = address, response delay chosen per pixel
   initial begin
      int cd, a;
      logic [71:0] col;
      cd = 0;
      col = '0;
      ray_done = 1'b0;
      pixel_color = '0;
      forever begin
         @(negedge clk);
         ray_done = 1'b0;
         if (ray_valid) begin
            a = int'(pixel_v) * 4 + int'(pixel_h);
            cd = a == mute_a ? 0 : a == sim_a ? 20 : a == long_a ? 15 : 5;
            col = 72'(a);
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               ray_done = 1'b1;
               pixel_color = col;
               if (!busy) late_fired = 1'b1;
            end
         end
      end
   end

   // monitor, scoreboard and framebuffer ready driver
   initial begin
      logic [10:0] ph;
      logic [9:0] pv;
      logic pb, pvld;
      int a;
      ph = '0;
      pv = '0;
      pb = 1'b0;
      pvld = 1'b0;
      fb_wr_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         age = (pixel_h !== ph || pixel_v !== pv || (busy && !pb)) ? 0 : age + 1;
         ph = pixel_h;
         pv = pixel_v;
         pb = busy;
         if (ray_valid) begin
            a = int'(pixel_v) * 4 + int'(pixel_h);
            check("rv_age", 72'(age), 72'(3));
            check("rv_addr", 72'(a), 72'(rv_idx % 8));
            rv_idx++;
            rv_last = a;
            rv_cyc = cyc;
         end
         if (fb_wr_valid && int'(fb_wr_addr) == stall_a && stall_left > 0) begin
            fb_wr_ready = 1'b0;
            stall_left--;
            check("stall_addr", 72'(fb_wr_addr), 72'(1));
            check("stall_data", fb_wr_data, 72'(1));
            check("stall_h", 72'(pixel_h), 72'(1));
            check("stall_v", 72'(pixel_v), 72'(0));
            check("stall_rv", 72'(ray_valid), 72'(0));
         end else fb_wr_ready = 1'b1;
         if (fb_wr_valid && !pvld) begin
            check("wr_lat", 72'(cyc - rv_cyc), 72'(exp_lat(rv_last)));
            if (rv_last == mute_a || rv_last == sim_a)
               check("wr_terr", 72'(timeout_err), 72'(rv_last == mute_a));
         end
         pvld = fb_wr_valid;
         if (fb_wr_valid && fb_wr_ready) begin
            a = wr_idx % 8;
            check("wr_addr", 72'(fb_wr_addr), 72'(a));
            check("wr_data", fb_wr_data, a == mute_a ? ERR : 72'(a));
            wr_idx++;
            n_wr++;
         end
         if (frame_done) begin
            fc_exp++;
            n_fd++;
            check("frame_count", 72'(frame_count), 72'(fc_exp));
         end
      end
   end

   task automatic pulse_start;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_fd(input int target);
      int t;
      t = 0;
      while (n_fd < target && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("frame_wait", 72'(n_fd >= target), 72'(1));
   endtask

   task automatic chk_zero;
      check("z_h", 72'(pixel_h), 72'(0));
      check("z_v", 72'(pixel_v), 72'(0));
      check("z_rv", 72'(ray_valid), 72'(0));
      check("z_wv", 72'(fb_wr_valid), 72'(0));
      check("z_addr", 72'(fb_wr_addr), 72'(0));
      check("z_data", fb_wr_data, 72'(0));
      check("z_busy", 72'(busy), 72'(0));
      check("z_fd", 72'(frame_done), 72'(0));
      check("z_fc", 72'(frame_count), 72'(0));
      check("z_terr", 72'(timeout_err), 72'(0));
   endtask

   initial begin
      int t;
      rst_n = 1'b0;
      start = 1'b0;
      continuous = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero();
      rst_n = 1'b1;
      stall_a = 1;
      stall_left = 10;
      pulse_start();
      wait_fd(1);
      @(negedge clk);
      check("f1_writes", 72'(n_wr), 72'(8));
      check("f1_rays", 72'(rv_idx), 72'(8));
      check("f1_stalled", 72'(stall_left), 72'(0));
      check("f1_idle", 72'(busy), 72'(0));
      check("f1_fc", 72'(frame_count), 72'(1));
      check("f1_terr", 72'(timeout_err), 72'(0));
      sim_a = 3;
      pulse_start();
      wait_fd(2);
      @(negedge clk);
      check("f2_writes", 72'(n_wr), 72'(16));
      check("f2_terr", 72'(timeout_err), 72'(0));
      sim_a = -1;
      mute_a = 6;
      pulse_start();
      wait_fd(3);
      repeat (5) @(negedge clk);
      check("f3_writes", 72'(n_wr), 72'(24));
      check("f3_terr", 72'(timeout_err), 72'(1));
      check("f3_fc", 72'(frame_count), 72'(3));
      check("f3_idle", 72'(busy), 72'(0));
      mute_a = -1;
      long_a = 2;
      pulse_start();
      t = 0;
      while (rv_last != 2 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("rw_reach", 72'(rv_last), 72'(2));
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_wr = 0;
      wr_idx = 0;
      rv_idx = 0;
      fc_exp = 0;
      n_fd = 0;
      chk_zero();
      repeat (25) @(negedge clk);
      check("late_fired", 72'(late_fired), 72'(1));
      check("late_writes", 72'(n_wr), 72'(0));
      check("late_busy", 72'(busy), 72'(0));
      check("late_wv", 72'(fb_wr_valid), 72'(0));
      long_a = -1;
      continuous = 1'b1;
      pulse_start();
      repeat (10) @(negedge clk);
      pulse_start();
      wait_fd(1);
      check("c1_busy", 72'(busy), 72'(1));
      pulse_start();
      wait_fd(2);
      check("c2_busy", 72'(busy), 72'(1));
      continuous = 1'b0;
      wait_fd(3);
      repeat (3) @(negedge clk);
      check("c_idle", 72'(busy), 72'(0));
      check("c_fc", 72'(frame_count), 72'(3));
      check("c_writes", 72'(n_wr), 72'(24));
      check("c_rays", 72'(rv_idx), 72'(24));
      check("c_terr", 72'(timeout_err), 72'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
      $fatal(1);
   end
endmodule
